// File: rtl/sot_align_ctrl.sv
// Start-of-transmission alignment controller: pulses per-VFAT frame-aligner resets,
// waits for lock with a timeout and bounded retries, and relocks on lock loss.
module sot_align_ctrl #(
  parameter int MXVFATS     = 12,
  parameter int MAX_RETRIES = 3,
  parameter int RST_CYCLES  = 4
) (
  input  logic               clock,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic [MXVFATS-1:0] mask_i,
  input  logic [MXVFATS-1:0] sot_is_aligned_i,
  input  logic [MXVFATS-1:0] sot_unstable_i,
  input  logic [15:0]        timeout_i,
  output logic [MXVFATS-1:0] aligner_reset_o,
  output logic               all_aligned_o,
  output logic [MXVFATS-1:0] failed_o,
  output logic [2:0]         state_o,
  output logic [1:0]         retry_cnt_o,
  output logic [7:0]         unstable_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } state_e;

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_e               state, state_nxt;
  logic [RCW-1:0]       rst_cnt, rst_cnt_nxt;
  logic [15:0]          timer, timer_nxt;
  logic [1:0]           retry, retry_nxt;
  logic [MXVFATS-1:0]   failed, failed_nxt;
  logic [7:0]           unstable_cnt, unstable_cnt_nxt;
  logic                 all_aligned;

  logic good, bad, pulse_done, timeout_hit, retry_left;

  // Masked VFATs count as aligned and never as unstable.
  assign good        = &(sot_is_aligned_i | mask_i);
  assign bad         = |((sot_unstable_i | ~sot_is_aligned_i) & ~mask_i);
  assign pulse_done  = (rst_cnt == RCW'(RST_CYCLES - 1));
  assign timeout_hit = (timer == timeout_i);
  assign retry_left  = (int'(retry) < MAX_RETRIES);

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_nxt        = state;
    retry_nxt        = retry;
    failed_nxt       = failed;
    unstable_cnt_nxt = unstable_cnt;

    if (!enable_i) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_nxt  = ST_RESET;
          retry_nxt  = '0;
          failed_nxt = '0;
        end
        ST_RESET: begin
          if (pulse_done) state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          // Lock wins over a timeout landing in the same cycle.
          if (good) begin
            state_nxt = ST_LOCKED;
          end else if (timeout_hit) begin
            if (retry_left) begin
              retry_nxt = retry + 2'd1;
              state_nxt = ST_RESET;
            end else begin
              failed_nxt = ~sot_is_aligned_i & ~mask_i;
              state_nxt  = ST_FAIL;
            end
          end
        end
        ST_LOCKED: begin
          if (bad) begin
            unstable_cnt_nxt = (unstable_cnt == 8'hFF) ? unstable_cnt : unstable_cnt + 8'd1;
            retry_nxt        = '0;
            state_nxt        = ST_RESET;
          end
        end
        ST_FAIL: state_nxt = ST_FAIL;
        default: state_nxt = ST_IDLE;
      endcase
    end

    // Both counters restart from zero on every entry into their state.
    rst_cnt_nxt = (state == ST_RESET && state_nxt == ST_RESET) ? rst_cnt + RCW'(1) : '0;
    timer_nxt   = (state == ST_WAIT  && state_nxt == ST_WAIT)  ? timer + 16'd1    : '0;
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset_i) begin
      state        <= ST_IDLE;
      rst_cnt      <= '0;
      timer        <= '0;
      retry        <= '0;
      failed       <= '0;
      unstable_cnt <= '0;
      all_aligned  <= 1'b0;
    end else begin
      state        <= state_nxt;
      rst_cnt      <= rst_cnt_nxt;
      timer        <= timer_nxt;
      retry        <= retry_nxt;
      failed       <= failed_nxt;
      unstable_cnt <= unstable_cnt_nxt;
      all_aligned  <= (state_nxt == ST_LOCKED);
    end
  end

  // Pulse follows the live mask and is cut immediately when enable drops.
  assign aligner_reset_o = (state == ST_RESET && enable_i) ? ~mask_i : '0;
  assign all_aligned_o   = all_aligned;
  assign failed_o        = failed;
  assign state_o         = state;
  assign retry_cnt_o     = retry;
  assign unstable_cnt_o  = unstable_cnt;

endmodule

// File: tb/tb_sot_align_ctrl.sv
// Directed bench for sot_align_ctrl: expectations are queued as stimulus is applied
// and compared against DUT outputs one cycle-phase after the active edge.
module tb_sot_align_ctrl;

  localparam int MX = 12;

  logic          clock = 1'b0;
  logic          reset_i;
  logic          enable_i;
  logic [MX-1:0] mask_i;
  logic [MX-1:0] sot_is_aligned_i;
  logic [MX-1:0] sot_unstable_i;
  logic [15:0]   timeout_i;
  logic [MX-1:0] aligner_reset_o;
  logic          all_aligned_o;
  logic [MX-1:0] failed_o;
  logic [2:0]    state_o;
  logic [1:0]    retry_cnt_o;
  logic [7:0]    unstable_cnt_o;

  sot_align_ctrl #(.MXVFATS(MX), .MAX_RETRIES(3), .RST_CYCLES(4)) dut (
    .clock            (clock),
    .reset_i          (reset_i),
    .enable_i         (enable_i),
    .mask_i           (mask_i),
    .sot_is_aligned_i (sot_is_aligned_i),
    .sot_unstable_i   (sot_unstable_i),
    .timeout_i        (timeout_i),
    .aligner_reset_o  (aligner_reset_o),
    .all_aligned_o    (all_aligned_o),
    .failed_o         (failed_o),
    .state_o          (state_o),
    .retry_cnt_o      (retry_cnt_o),
    .unstable_cnt_o   (unstable_cnt_o)
  );

  always #5 clock = ~clock;

  localparam logic [2:0] S_IDLE = 3'd0, S_RESET = 3'd1, S_WAIT = 3'd2,
                         S_LOCKED = 3'd3, S_FAIL = 3'd4;

  typedef enum int {F_STATE, F_ARST, F_ALL, F_FAILED, F_RETRY, F_UNST} field_e;
  typedef struct {
    string       tag;
    field_e      f;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   exp_unst;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_val(input string tag, input field_e f, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.f   = f;
    e.v   = v;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input field_e f);
    case (f)
      F_STATE:  return 32'(state_o);
      F_ARST:   return 32'(aligner_reset_o);
      F_ALL:    return 32'(all_aligned_o);
      F_FAILED: return 32'(failed_o);
      F_RETRY:  return 32'(retry_cnt_o);
      default:  return 32'(unstable_cnt_o);
    endcase
  endfunction

  task automatic check();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.f);
      n_assert++;
      assert (obs === e.v) else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (state_o === s) break;
      step(1);
    end
    n_assert++;
    assert (state_o === s) else begin
      n_fail++;
      $error("FAIL %s: observed state %0d expected %0d within %0d cycles", tag, state_o, s, budget);
    end
  endtask

  initial begin
    // Reset dominates enable.
    reset_i = 1'b1; enable_i = 1'b1; mask_i = '0;
    sot_is_aligned_i = '0; sot_unstable_i = '0; timeout_i = 16'd1000;
    step(2);
    expect_val("rst_state",  F_STATE,  S_IDLE);
    expect_val("rst_arst",   F_ARST,   0);
    expect_val("rst_all",    F_ALL,    0);
    expect_val("rst_failed", F_FAILED, 0);
    expect_val("rst_retry",  F_RETRY,  0);
    expect_val("rst_unst",   F_UNST,   0);
    check();

    // Lock path: four full-width reset pulses, lock 10 cycles into WAIT.
    reset_i = 1'b0;
    step(1);
    for (int i = 0; i < 4; i++) begin
      expect_val("lock_rst_state", F_STATE, S_RESET);
      expect_val("lock_rst_arst",  F_ARST,  32'hFFF);
      check();
      step(1);
    end
    expect_val("lock_wait_state", F_STATE, S_WAIT);
    expect_val("lock_wait_arst",  F_ARST,  0);
    expect_val("lock_wait_all",   F_ALL,   0);
    check();
    step(9);
    expect_val("lock_wait9_state", F_STATE, S_WAIT);
    check();
    sot_is_aligned_i = '1;
    step(1);
    expect_val("lock_state", F_STATE, S_LOCKED);
    expect_val("lock_all",   F_ALL,   1);
    expect_val("lock_retry", F_RETRY, 0);
    check();

    // Lock loss on VFAT 2, repeated past counter saturation.
    exp_unst = 0;
    for (int k = 0; k < 300; k++) begin
      sot_unstable_i = 12'h004;
      step(1);
      sot_unstable_i = '0;
      exp_unst = (exp_unst == 255) ? 255 : exp_unst + 1;
      expect_val("loss_state", F_STATE, S_RESET);
      expect_val("loss_unst",  F_UNST,  32'(exp_unst));
      expect_val("loss_all",   F_ALL,   0);
      expect_val("loss_retry", F_RETRY, 0);
      check();
      if (k == 0) begin
        for (int i = 0; i < 4; i++) begin
          expect_val("loss_arst", F_ARST, 32'hFFF);
          check();
          step(1);
        end
        expect_val("loss_wait_state", F_STATE, S_WAIT);
        expect_val("loss_wait_arst",  F_ARST,  0);
        check();
      end
      wait_state("loss_relock", S_LOCKED, 20);
    end
    expect_val("loss_sat_unst", F_UNST, 255);
    check();

    // Enable drop from LOCKED, then abort during the second reset cycle.
    enable_i = 1'b0;
    step(1);
    expect_val("dis_state", F_STATE, S_IDLE);
    expect_val("dis_all",   F_ALL,   0);
    expect_val("dis_unst",  F_UNST,  255);
    check();
    enable_i = 1'b1;
    step(1);
    expect_val("abort_c1_arst", F_ARST, 32'hFFF);
    check();
    step(1);
    expect_val("abort_c2_state", F_STATE, S_RESET);
    check();
    enable_i = 1'b0;
    step(1);
    expect_val("abort_state", F_STATE, S_IDLE);
    expect_val("abort_arst",  F_ARST,  0);
    expect_val("abort_unst",  F_UNST,  255);
    check();

    // Retries exhausted with VFAT 5 never aligning.
    sot_is_aligned_i = 12'hFDF; timeout_i = 16'd100; enable_i = 1'b1;
    step(1);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) begin
        expect_val("retry_rst_state", F_STATE, S_RESET);
        expect_val("retry_rst_cnt",   F_RETRY, 32'(r));
        expect_val("retry_rst_arst",  F_ARST,  32'hFFF);
        check();
        step(1);
      end
      expect_val("retry_wait_state", F_STATE, S_WAIT);
      expect_val("retry_wait_cnt",   F_RETRY, 32'(r));
      check();
      step(100);
      expect_val("retry_wait_t100", F_STATE, S_WAIT);
      check();
      step(1);
    end
    expect_val("fail_state",  F_STATE,  S_FAIL);
    expect_val("fail_failed", F_FAILED, 32'h020);
    expect_val("fail_retry",  F_RETRY,  3);
    expect_val("fail_all",    F_ALL,    0);
    check();
    sot_unstable_i = '1;
    step(5);
    sot_unstable_i = '0;
    expect_val("fail_hold_state",  F_STATE,  S_FAIL);
    expect_val("fail_hold_failed", F_FAILED, 32'h020);
    expect_val("fail_hold_unst",   F_UNST,   255);
    check();

    // Reset from FAIL.
    reset_i = 1'b1; enable_i = 1'b0;
    step(1);
    expect_val("frst_state",  F_STATE,  S_IDLE);
    expect_val("frst_failed", F_FAILED, 0);
    expect_val("frst_unst",   F_UNST,   0);
    expect_val("frst_retry",  F_RETRY,  0);
    check();
    reset_i = 1'b0;

    // Everything masked: zero-width pulses, immediate lock, masked drops ignored.
    mask_i = '1; sot_is_aligned_i = '0; enable_i = 1'b1;
    step(1);
    for (int i = 0; i < 4; i++) begin
      expect_val("mask_rst_state", F_STATE, S_RESET);
      expect_val("mask_rst_arst",  F_ARST,  0);
      check();
      step(1);
    end
    expect_val("mask_wait_state", F_STATE, S_WAIT);
    expect_val("mask_wait_arst",  F_ARST,  0);
    check();
    step(1);
    expect_val("mask_lock_state", F_STATE, S_LOCKED);
    expect_val("mask_lock_all",   F_ALL,   1);
    check();
    sot_unstable_i = 12'h008;
    step(2);
    sot_unstable_i = '0;
    expect_val("mask_unst_state", F_STATE, S_LOCKED);
    check();

    // Unmask non-aligned VFAT 3 while LOCKED forces a relock.
    sot_is_aligned_i = 12'hFF7; mask_i = 12'hFF7;
    step(1);
    expect_val("unmask_state", F_STATE, S_RESET);
    expect_val("unmask_arst",  F_ARST,  32'h008);
    expect_val("unmask_unst",  F_UNST,  1);
    expect_val("unmask_all",   F_ALL,   0);
    check();

    // Zero timeout decides in the first WAIT cycle; lock beats a same-cycle timeout.
    timeout_i = 16'd0;
    wait_state("t0_wait", S_WAIT, 10);
    expect_val("t0_wait_retry", F_RETRY, 0);
    check();
    step(1);
    expect_val("t0_state", F_STATE, S_RESET);
    expect_val("t0_retry", F_RETRY, 1);
    check();
    sot_is_aligned_i = '1;
    wait_state("prio_wait", S_WAIT, 10);
    step(1);
    expect_val("prio_state", F_STATE, S_LOCKED);
    expect_val("prio_retry", F_RETRY, 1);
    expect_val("prio_all",   F_ALL,   1);
    check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
